// File: rtl/nch_mixer_pkg.sv
// Shared constants, field widths and types for the N-channel frame mixer.
// Header/footer codes follow the ADC frame format; FRAME_ERR bit positions are fixed here.
package nch_mixer_pkg;

    localparam logic [7:0] HEADER_ID = 8'hFF;
    localparam logic [3:0] FOOTER_HI = 4'hF;
    localparam logic [7:0] FOOTER_LO = 8'h0F;
    localparam logic [7:0] LOST_LO   = 8'h00;

    localparam int HDR_ID_W = 8;
    localparam int FTR_HI_W = 4;
    localparam int FTR_LO_W = 8;
    localparam int CH_ID_W  = 4;

    localparam int ERR_W       = 3;
    localparam int ERR_NO_HDR  = 0;
    localparam int ERR_NO_FTR  = 1;
    localparam int ERR_TIMEOUT = 2;

    typedef enum logic {
        ARB    = 1'b0,
        STREAM = 1'b1
    } mix_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester strictly after ptr_i, wrapping; one-hot and index out.
// Latency: combinational. Backpressure: none, the caller decides when to latch the grant.
// Flow: purely combinational, no handshake of its own.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_CH-1:0]  gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        // i == N_CH wraps back to ptr itself, so the last owner is considered last
        for (int i = 1; i <= N_CH; i++) begin
            if (!gnt_vld_o && req_i[(int'(ptr_i) + i) % N_CH]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IDX_W'((int'(ptr_i) + i) % N_CH);
                gnt_oh_o[(int'(ptr_i) + i) % N_CH] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nch_frame_mixer.sv
// Frame-atomic round-robin merge of N_CH frame streams with channel-ID stamping and integrity flags.
// Latency: first word 2 cycles after request when idle, then 1 word/cycle; 1-cycle bubble per frame.
// Backpressure: output register holds while !iREADY; granted CH_oREADY = !oVALID || iREADY. MIXER_STALL_TIMEOUT_EN adds stall close-out.
module nch_frame_mixer
    import nch_mixer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int N_CH       = 4,
    parameter int CH_ID_LSB  = 52,
    parameter int TIMEOUT    = 256
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic [N_CH*DATA_WIDTH-1:0] CH_DIN,
    input  logic [N_CH-1:0]            CH_iVALID,
    input  logic [N_CH-1:0]            CH_iLAST,
    output logic [N_CH-1:0]            CH_oREADY,
    output logic [DATA_WIDTH-1:0]      DOUT,
    output logic                       oVALID,
    output logic                       oLAST,
    input  logic                       iREADY,
    output logic [ERR_W-1:0]           FRAME_ERR
);

    localparam int IDX_W = $clog2(N_CH);

    mix_state_e            state_q, state_d;
    logic [IDX_W-1:0]      gnt_q, gnt_d, ptr_q, ptr_d;
    logic [N_CH-1:0]       gnt_oh_q, gnt_oh_d;
    logic                  first_q, first_d, hdr_bad_q, hdr_bad_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovld_q, ovld_d, olast_q, olast_d;
    logic [ERR_W-1:0]      err_q, err_d;

    logic [N_CH-1:0]       arb_oh;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_vld;
    logic [DATA_WIDTH-1:0] cur_word, stamped;
    logic                  cur_vld, cur_last, out_free, take, is_hdr, is_ftr, tmo_hit;

    rr_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
        .req_i    (CH_iVALID),
        .ptr_i    (ptr_q),
        .gnt_oh_o (arb_oh),
        .gnt_idx_o(arb_idx),
        .gnt_vld_o(arb_vld)
    );

    assign cur_word = CH_DIN[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
    assign cur_vld  = CH_iVALID[gnt_q];
    assign cur_last = CH_iLAST[gnt_q];
    assign out_free = !ovld_q || iREADY;
    assign take     = (state_q == STREAM) && cur_vld && out_free;
    assign is_hdr   = (cur_word[DATA_WIDTH-1 -: HDR_ID_W] == HEADER_ID);
    assign is_ftr   = (cur_word[DATA_WIDTH-1 -: FTR_HI_W] == FOOTER_HI) &&
                      (cur_word[FTR_LO_W-1:0] == FOOTER_LO);

    always_comb begin
        stamped = cur_word;
        stamped[CH_ID_LSB +: CH_ID_W] = CH_ID_W'(gnt_q);
    end

`ifdef MIXER_STALL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // counts consecutive starved cycles of the granted channel; saturates at TIMEOUT
    assign tmo_hit = (state_q == STREAM) && !cur_vld && (tmo_q >= TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        if (state_q == STREAM && !cur_vld) begin
            tmo_d = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_oh_d  = gnt_oh_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        hdr_bad_d = hdr_bad_q;
        dout_d    = dout_q;
        ovld_d    = ovld_q;
        olast_d   = olast_q;
        err_d     = err_q;

        if (ovld_q && iREADY) begin
            ovld_d  = 1'b0;
            olast_d = 1'b0;
            err_d   = '0;
        end

        case (state_q)
            ARB: begin
                if (arb_vld) begin
                    gnt_d    = arb_idx;
                    gnt_oh_d = arb_oh;
                    ptr_d    = arb_idx;
                    first_d  = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (take) begin
                    ovld_d    = 1'b1;
                    dout_d    = first_q ? stamped : cur_word;
                    olast_d   = cur_last;
                    first_d   = 1'b0;
                    hdr_bad_d = first_q ? !is_hdr : hdr_bad_q;
                    err_d     = '0;
                    // integrity flags are reported only on the closing beat
                    if (cur_last) begin
                        err_d[ERR_NO_HDR] = first_q ? !is_hdr : hdr_bad_q;
                        err_d[ERR_NO_FTR] = !is_ftr;
                        state_d           = ARB;
                    end
                end
`ifdef MIXER_STALL_TIMEOUT_EN
                else if (tmo_hit && out_free) begin
                    ovld_d                  = 1'b1;
                    dout_d                  = '0;
                    dout_d[FTR_LO_W-1:0]    = LOST_LO;
                    olast_d                 = 1'b1;
                    err_d                   = '0;
                    err_d[ERR_NO_FTR]       = 1'b1;
                    err_d[ERR_TIMEOUT]      = 1'b1;
                    state_d                 = ARB;
                end
`endif
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ARB;
            gnt_q     <= '0;
            gnt_oh_q  <= '0;
            ptr_q     <= IDX_W'(N_CH - 1);
            first_q   <= 1'b0;
            hdr_bad_q <= 1'b0;
            dout_q    <= '0;
            ovld_q    <= 1'b0;
            olast_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_oh_q  <= gnt_oh_d;
            ptr_q     <= ptr_d;
            first_q   <= first_d;
            hdr_bad_q <= hdr_bad_d;
            dout_q    <= dout_d;
            ovld_q    <= ovld_d;
            olast_q   <= olast_d;
            err_q     <= err_d;
        end
    end

    assign CH_oREADY = (state_q == STREAM && out_free) ? gnt_oh_q : '0;
    assign DOUT      = dout_q;
    assign oVALID    = ovld_q;
    assign oLAST     = olast_q;
    assign FRAME_ERR = err_q;

    // tmo_hit only feeds the optional close-out path
    logic unused_ok;
    assign unused_ok = tmo_hit;

endmodule

// File: tb/tb_nch_frame_mixer.sv
// Bench for nch_frame_mixer (default build): per-channel frame queues feed the DUT, and a
// per-channel expected-beat scoreboard built from the frame rules checks every output beat.
module tb_nch_frame_mixer;

    localparam int DW  = 64;
    localparam int NC  = 4;
    localparam int IDL = 52;

    logic            CLK       = 1'b0;
    logic            RESETN    = 1'b0;
    logic [NC*DW-1:0] CH_DIN   = '0;
    logic [NC-1:0]   CH_iVALID = '0;
    logic [NC-1:0]   CH_iLAST  = '0;
    logic [NC-1:0]   CH_oREADY;
    logic [DW-1:0]   DOUT;
    logic            oVALID, oLAST;
    logic            iREADY    = 1'b0;
    logic [2:0]      FRAME_ERR;

    nch_frame_mixer #(.DATA_WIDTH(DW), .N_CH(NC), .CH_ID_LSB(IDL), .TIMEOUT(16)) dut (
        .CLK(CLK), .RESETN(RESETN), .CH_DIN(CH_DIN), .CH_iVALID(CH_iVALID),
        .CH_iLAST(CH_iLAST), .CH_oREADY(CH_oREADY), .DOUT(DOUT), .oVALID(oVALID),
        .oLAST(oLAST), .iREADY(iREADY), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0, cyc = 0, stall_cnt = 0;
    int gap_pct = 0, rdy_pct = 100;
    logic [64:0] src_q [NC][$];   // {last, raw word} still to be offered
    logic [67:0] exp_q [NC][$];   // {err, last, stamped word} expected on DOUT
    logic [NC-1:0] acc;
    int rise_cyc [NC];
    int first_lat [NC];
    logic [2:0] last_err [NC];
    int order_q[$];
    int gap_q[$];
    bit in_frame = 1'b0, have_end = 1'b0;
    int cur_ch = 0, end_cyc = 0;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int c, input int len, input logic [7:0] hdr, input logic [7:0] ftr_lo);
        logic [63:0] w;
        logic [2:0]  e;
        logic        hb;
        hb = 1'b0;
        for (int i = 0; i < len; i++) begin
            w = {$urandom, $urandom};
            if (i == 0) w[63:56] = hdr;
            if (i == len - 1) begin
                w[63:60] = 4'hF;
                w[7:0]   = ftr_lo;
            end
            src_q[c].push_back({(i == len - 1), w});
            if (i == 0) begin
                hb = (w[63:56] != 8'hFF);
                w[IDL +: 4] = 4'(c);
            end
            e = 3'b000;
            if (i == len - 1) e = {1'b0, !(w[63:60] == 4'hF && w[7:0] == 8'h0F), hb};
            exp_q[c].push_back({e, (i == len - 1), w});
        end
    endtask

    task automatic look(input bit pop);
        int ch;
        int avail;
        logic [67:0] obs, ex;
        obs   = {FRAME_ERR, oLAST, DOUT};
        ch    = in_frame ? cur_ch : int'(DOUT[IDL +: 4]);
        avail = (ch < NC) ? exp_q[ch].size() : 0;
        chk("beat_has_source", 68'(avail > 0), 68'd1);
        if (avail > 0) begin
            ex = exp_q[ch][0];
            if (pop) chk("beat", obs, ex);
            else     chk("held", obs, ex);
            if (pop) begin
                void'(exp_q[ch].pop_front());
                if (!in_frame) begin
                    order_q.push_back(ch);
                    if (have_end) gap_q.push_back(cyc - end_cyc);
                    first_lat[ch] = cyc - rise_cyc[ch];
                end
                in_frame = !ex[64];
                cur_ch   = ch;
                if (ex[64]) begin
                    have_end     = 1'b1;
                    end_cyc      = cyc;
                    last_err[ch] = FRAME_ERR;
                end
            end
        end
    endtask

    // monitor on the falling edge, drive 1 time unit after the rising edge
    initial begin
        forever begin
            @(negedge CLK);
            acc = CH_iVALID & CH_oREADY;
            if (RESETN && oVALID) begin
                look(iREADY);
                if (!iREADY) begin
                    stall_cnt++;
                    chk("stall_ready", 68'(CH_oREADY), 68'd0);
                end
            end
            @(posedge CLK);
            cyc++;
            #1;
            for (int c = 0; c < NC; c++) begin
                bit nv;
                if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                nv = (src_q[c].size() > 0) && (int'($urandom_range(99)) >= gap_pct);
                if (nv && !CH_iVALID[c]) rise_cyc[c] = cyc;
                CH_iVALID[c] = nv;
                if (nv) begin
                    CH_iLAST[c]          = src_q[c][0][64];
                    CH_DIN[c*DW +: DW]   = src_q[c][0][63:0];
                end else begin
                    CH_iLAST[c]          = 1'b0;
                    CH_DIN[c*DW +: DW]   = '0;
                end
            end
            iREADY = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    task automatic flush();
        for (int c = 0; c < NC; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
        end
        in_frame = 1'b0;
        have_end = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RESETN = 1'b0;
        flush();
        repeat (2) @(posedge CLK);
        #2;
        RESETN = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int left;
        int n;
        n = 0;
        forever begin
            left = 0;
            for (int c = 0; c < NC; c++) left += exp_q[c].size() + src_q[c].size();
            if (left == 0 || n >= budget) break;
            @(posedge CLK);
            n++;
        end
        chk("drain_left", 68'(left), 68'd0);
        repeat (2) @(posedge CLK);
        #2;
    endtask

    task automatic wait_words(input int c, input int remain);
        int n;
        n = 0;
        while (exp_q[c].size() > remain && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        chk("wait_words", 68'(exp_q[c].size() <= remain), 68'd1);
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int p;
        for (int c = 0; c < NC; c++) begin
            rise_cyc[c]  = 0;
            first_lat[c] = 0;
            last_err[c]  = 3'b000;
        end

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_dout", 68'(DOUT), 68'd0);
        chk("rst_ctrl", 68'({FRAME_ERR, oLAST, oVALID, CH_oREADY}), 68'd0);
        @(posedge CLK);
        #2;
        RESETN = 1'b1;

        // T1: single channel long frame, latency and stamping
        add_frame(2, 162, 8'hFF, 8'h0F);
        wait_drain(2000);
        chk("t1_latency", 68'(first_lat[2]), 68'd2);
        chk("t1_err", 68'(last_err[2]), 68'd0);
        chk("t1_frames", 68'(order_q.size()), 68'd1);

        // T2: all channels backlogged right after reset
        do_reset();
        order_q.delete();
        gap_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NC; c++) add_frame(c, $urandom_range(3, 8), 8'hFF, 8'h0F);
        wait_drain(2000);
        chk("t2_frames", 68'(order_q.size()), 68'd8);
        p = NC - 1;
        for (int i = 0; i < order_q.size() && i < 8; i++) begin
            p = (p + 1) % NC;
            chk("t2_order", 68'(order_q[i]), 68'(p));
        end
        chk("t2_gaps", 68'(gap_q.size()), 68'd7);
        foreach (gap_q[i]) chk("t2_bubble", 68'(gap_q[i]), 68'd2);

        // T3: integrity flags, including single-word frames
        add_frame(1, 5, 8'h00, 8'h0F);
        add_frame(0, 6, 8'hFF, 8'h00);
        add_frame(3, 1, 8'hFF, 8'h0F);
        add_frame(2, 1, 8'hFF, 8'h00);
        wait_drain(2000);
        chk("t3_no_header", 68'(last_err[1]), 68'd1);
        chk("t3_no_footer", 68'(last_err[0]), 68'd2);
        chk("t3_single_ok", 68'(last_err[3]), 68'd0);
        chk("t3_single_lost", 68'(last_err[2]), 68'd2);

        // T4: downstream stall mid-frame
        stall_cnt = 0;
        add_frame(1, 30, 8'hFF, 8'h0F);
        wait_words(1, 20);
        rdy_pct = 0;
        repeat (10) @(posedge CLK);
        #2;
        rdy_pct = 100;
        wait_drain(2000);
        chk("t4_stalled", 68'(stall_cnt >= 8), 68'd1);

        // random traffic with source gaps and downstream backpressure
        gap_pct = 30;
        rdy_pct = 70;
        for (int f = 0; f < 40; f++) begin
            add_frame($urandom_range(0, NC - 1), $urandom_range(1, 12),
                      ($urandom_range(99) < 85) ? 8'hFF : 8'($urandom),
                      ($urandom_range(99) < 85) ? 8'h0F : 8'h00);
        end
        wait_drain(20000);

        // T6: reset in the middle of a frame
        gap_pct = 0;
        rdy_pct = 100;
        add_frame(3, 40, 8'hFF, 8'h0F);
        wait_words(3, 30);
        RESETN = 1'b0;
        #1;
        chk("t6_rst_dout", 68'(DOUT), 68'd0);
        chk("t6_rst_ctrl", 68'({FRAME_ERR, oLAST, oVALID, CH_oREADY}), 68'd0);
        flush();
        repeat (2) @(posedge CLK);
        #2;
        RESETN = 1'b1;
        order_q.delete();
        add_frame(3, 4, 8'hFF, 8'h0F);
        add_frame(0, 4, 8'hFF, 8'h0F);
        wait_drain(2000);
        chk("t6_frames", 68'(order_q.size()), 68'd2);
        if (order_q.size() == 2) begin
            chk("t6_first_ch", 68'(order_q[0]), 68'd0);
            chk("t6_second_ch", 68'(order_q[1]), 68'd3);
        end
        chk("t6_err", 68'(last_err[0]), 68'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
